// File: rtl/seq_multiplier.sv
// 32x32 -> 64-bit sequential shift-add multiplier: one partial product per cycle, 32 iterations.
// Optional signed support (sgn port, magnitude multiply plus final negation) enabled by `define MULT_SIGNED_EN.
module seq_multiplier (
    input  logic        clk,
    input  logic        rst,
`ifdef MULT_SIGNED_EN
    input  logic        sgn,
`endif
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result_lo,
    output logic [31:0] result_hi
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PROD_W-1:0]   r_mcand;
    logic [PROD_W-1:0]   w_mcand_nxt;
    logic [DATA_W-1:0]   r_mplier;
    logic [DATA_W-1:0]   w_mplier_nxt;
    logic [PROD_W-1:0]   r_acc;
    logic [PROD_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_neg;
    logic                w_neg_nxt;
    logic [PROD_W-1:0]   r_res;
    logic [PROD_W-1:0]   w_res_nxt;
    logic                r_busy;
    logic                r_done;

    logic                w_a_neg;
    logic                w_b_neg;
    logic [DATA_W-1:0]   w_a_mag;
    logic [DATA_W-1:0]   w_b_mag;
    logic [PROD_W-1:0]   w_step;
    logic [PROD_W-1:0]   w_prod;

    // Operands are reduced to magnitudes so the iteration is always unsigned.
`ifdef MULT_SIGNED_EN
    assign w_a_neg = sgn & a[DATA_W-1];
    assign w_b_neg = sgn & b[DATA_W-1];
`else
    assign w_a_neg = 1'b0;
    assign w_b_neg = 1'b0;
`endif

    assign w_a_mag = w_a_neg ? DATA_W'(~a + 32'd1) : a;
    assign w_b_mag = w_b_neg ? DATA_W'(~b + 32'd1) : b;

    assign w_step  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod  = r_neg ? PROD_W'(~w_step + 64'd1) : w_step;

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt  = r_state;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_neg_nxt    = r_neg;
        w_res_nxt    = r_res;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt  = S_RUN;
                    w_mcand_nxt  = PROD_W'(w_a_mag);
                    w_mplier_nxt = w_b_mag;
                    w_acc_nxt    = '0;
                    w_cnt_nxt    = '0;
                    w_neg_nxt    = w_a_neg ^ w_b_neg;
                end
            end
            S_RUN: begin
                w_acc_nxt    = w_step;
                w_mcand_nxt  = r_mcand << 1;
                w_mplier_nxt = r_mplier >> 1;
                w_cnt_nxt    = r_cnt + 5'd1;
                if (r_cnt == CNT_W'(DATA_W - 1)) begin
                    w_state_nxt = S_DONE;
                    w_res_nxt   = w_prod;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_res    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_neg    <= w_neg_nxt;
            r_res    <= w_res_nxt;
            r_busy   <= (w_state_nxt == S_RUN);
            r_done   <= (w_state_nxt == S_DONE);
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result_lo = r_res[DATA_W-1:0];
    assign result_hi = r_res[PROD_W-1:DATA_W];

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: vector table, scoreboard on done, latency/busy, start-hold and reset-abort sequences.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
`ifdef MULT_SIGNED_EN
    logic        sgn;
`endif

    seq_multiplier dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MULT_SIGNED_EN
        .sgn       (sgn),
`endif
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [63:0] prod;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] sb[$];
    int          done_cyc[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cyc.push_back(cyc);
            check("busy_done_exclusive", 64'(busy), 64'd0);
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got result %h%h with no operation outstanding", result_hi, result_lo);
            end else begin
                check("result", {result_hi, result_lo}, sb.pop_front());
            end
        end
    end

    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic isgn, input logic [63:0] exp);
        int lat;
        int nbusy;
        bit seen;
        @(negedge clk);
        a = ia;
        b = ib;
`ifdef MULT_SIGNED_EN
        sgn = isgn;
`endif
        start = 1'b1;
        sb.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
`ifdef MULT_SIGNED_EN
        sgn = ~isgn;
`endif
        lat   = 1;
        nbusy = 0;
        seen  = 1'b0;
        while (!seen && lat < 40) begin
            if (busy) nbusy++;
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check("done_latency", 64'(lat), 64'd33);
        check("busy_cycles", 64'(nbusy), 64'd32);
        @(negedge clk);
        check("idle_after_done", {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        int   guard;
        int   d0;
        logic [31:0] ra;
        logic [31:0] rb;

        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
`ifdef MULT_SIGNED_EN
        sgn   = 1'b0;
`endif
        #1 rst = 1'b1;
        #1;
        check("reset_outputs", {30'd0, busy, done, result_hi | result_lo}, 64'd0);
        check("reset_result", {result_hi, result_lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        vecs.push_back('{a: 32'd3,          b: 32'd5,          sgn: 1'b0, prod: 64'h00000000_0000000F});
        vecs.push_back('{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   sgn: 1'b0, prod: 64'hFFFFFFFE_00000001});
        vecs.push_back('{a: 32'd0,          b: 32'h12345678,   sgn: 1'b0, prod: 64'h0});
        vecs.push_back('{a: 32'hFFFFFFFD,   b: 32'd5,          sgn: 1'b0, prod: 64'h00000004_FFFFFFF1});
        vecs.push_back('{a: 32'h80000000,   b: 32'd2,          sgn: 1'b0, prod: 64'h00000001_00000000});
        vecs.push_back('{a: 32'hDEADBEEF,   b: 32'h10,         sgn: 1'b0, prod: 64'h0000000D_EADBEEF0});
        vecs.push_back('{a: 32'h80000000,   b: 32'h80000000,   sgn: 1'b0, prod: 64'h40000000_00000000});
`ifdef MULT_SIGNED_EN
        vecs.push_back('{a: 32'hFFFFFFFD,   b: 32'd5,          sgn: 1'b1, prod: 64'hFFFFFFFF_FFFFFFF1});
        vecs.push_back('{a: 32'h80000000,   b: 32'h80000000,   sgn: 1'b1, prod: 64'h40000000_00000000});
        vecs.push_back('{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   sgn: 1'b1, prod: 64'h00000000_00000001});
        vecs.push_back('{a: 32'd7,          b: 32'hFFFFFFFE,   sgn: 1'b1, prod: 64'hFFFFFFFF_FFFFFFF2});
`endif
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            vecs.push_back('{a: ra, b: rb, sgn: 1'b0, prod: 64'(ra) * 64'(rb)});
        end

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].prod);

        // start held high: back-to-back operations, operand change mid-RUN only affects the next one.
        d0 = done_cyc.size();
        @(negedge clk);
        a = 32'd2;
        b = 32'd4;
        start = 1'b1;
        sb.push_back(64'd8);
        sb.push_back(64'h3F);
        repeat (6) @(negedge clk);
        a = 32'd7;
        b = 32'd9;
        guard = 0;
        while (!done && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        a = 32'hA5A5A5A5;
        b = 32'h5A5A5A5A;
        guard = 0;
        while (!done && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        check("held_start_dones", 64'(done_cyc.size()), 64'(d0 + 2));
        if (done_cyc.size() >= d0 + 2)
            check("held_start_period", 64'(done_cyc[d0+1] - done_cyc[d0]), 64'd34);

        // Reset mid-operation aborts with no done pulse; results clear immediately.
        run_op(32'hFFFF, 32'hFFFF, 1'b0, 64'h00000000_FFFE0001);
        @(negedge clk);
        a = 32'h1234;
        b = 32'h5678;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_flags", {62'd0, busy, done}, 64'd0);
        check("abort_result", {result_hi, result_lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        d0 = done_cyc.size();
        repeat (40) @(negedge clk);
        check("no_done_after_abort", 64'(done_cyc.size()), 64'(d0));
        run_op(32'd2, 32'd2, 1'b0, 64'd4);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
